// File: rtl/wisc_flag_unit.sv
// Execute-stage {Z,V,N} condition-flag register with branch-condition evaluation.
// Also reports a pending flag write so the hazard logic can hold a dependent branch.
module wisc_flag_unit #(
    parameter int DW  = 16,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ex_valid,
    input  logic [OPW-1:0] ex_opcode,
    input  logic [DW-1:0]  alu_result,
    input  logic           alu_ovfl,
    input  logic           stall,
    input  logic           flush,
    input  logic [2:0]     br_ccc,
    output logic [2:0]     flags,
    output logic           flags_pending,
    output logic           br_taken
);

    localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0000);
    localparam logic [OPW-1:0] OP_SUB = OPW'(4'b0001);
    localparam logic [OPW-1:0] OP_XOR = OPW'(4'b0010);
    localparam logic [OPW-1:0] OP_SLL = OPW'(4'b0100);
    localparam logic [OPW-1:0] OP_SRA = OPW'(4'b0101);
    localparam logic [OPW-1:0] OP_ROR = OPW'(4'b0110);

    logic z_q, v_q, n_q;
    logic wr_all, wr_z, upd;

    // ADD/SUB write all three flags; logic/shift ops write only Z.
    always_comb begin
        wr_all = (ex_opcode == OP_ADD) || (ex_opcode == OP_SUB);
        wr_z   = wr_all || (ex_opcode == OP_XOR) || (ex_opcode == OP_SLL) ||
                 (ex_opcode == OP_SRA) || (ex_opcode == OP_ROR);
    end

    assign upd           = ex_valid & ~stall & ~flush;
    assign flags_pending = ex_valid & ~flush & wr_z;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_q <= 1'b0;
            v_q <= 1'b0;
            n_q <= 1'b0;
        end else if (upd) begin
            if (wr_z) z_q <= (alu_result == '0);
            if (wr_all) begin
                v_q <= alu_ovfl;
                n_q <= alu_result[DW-1];
            end
        end
    end

    assign flags = {z_q, v_q, n_q};

    // Evaluated only from registered flags; a same-cycle write is not bypassed.
    always_comb begin
        br_taken = 1'b0;
        unique case (br_ccc)
            3'b000:  br_taken = ~z_q;
            3'b001:  br_taken = z_q;
            3'b010:  br_taken = ~z_q & ~n_q;
            3'b011:  br_taken = n_q;
            3'b100:  br_taken = z_q | ~n_q;
            3'b101:  br_taken = n_q | z_q;
            3'b110:  br_taken = v_q;
            default: br_taken = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_wisc_flag_unit.sv
// Scoreboard bench for wisc_flag_unit: directed vectors queue hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_wisc_flag_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] alu_result;
    logic        alu_ovfl;
    logic        stall;
    logic        flush;
    logic [2:0]  br_ccc;
    logic [2:0]  flags;
    logic        flags_pending;
    logic        br_taken;

    wisc_flag_unit #(.DW(16), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .alu_result(alu_result), .alu_ovfl(alu_ovfl), .stall(stall), .flush(flush),
        .br_ccc(br_ccc), .flags(flags), .flags_pending(flags_pending), .br_taken(br_taken)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] fl;
        logic       pend;
        logic       br;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // One vector per cycle: drive inputs after the edge, queue what the outputs must show.
    task automatic step(input string nm, input logic rst, input logic v, input logic [3:0] op,
                        input logic [15:0] res, input logic ov, input logic st, input logic fl,
                        input logic [2:0] ccc, input logic [2:0] e_fl, input logic e_pend,
                        input logic e_br);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst; ex_valid = v; ex_opcode = op; alu_result = res; alu_ovfl = ov;
        stall = st; flush = fl; br_ccc = ccc;
        e.fl = e_fl; e.pend = e_pend; e.br = e_br;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic idle(input string nm, input logic [2:0] ccc, input logic [2:0] e_fl,
                        input logic e_br);
        step(nm, 1'b1, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, ccc, e_fl, 1'b0, e_br);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_tests += 3;
            if (flags !== e.fl) begin
                n_fail++;
                $display("FAIL %s flags: got %b expected %b", nm, flags, e.fl);
            end
            if (flags_pending !== e.pend) begin
                n_fail++;
                $display("FAIL %s flags_pending: got %b expected %b", nm, flags_pending, e.pend);
            end
            if (br_taken !== e.br) begin
                n_fail++;
                $display("FAIL %s br_taken: got %b expected %b (ccc=%b)", nm, br_taken, e.br, br_ccc);
            end
        end
    end

    logic [15:0] sw_res [3] = '{16'h0005, 16'hFFFB, 16'h0000};
    logic [2:0]  sw_fl  [3] = '{3'b000, 3'b001, 3'b100};
    logic [7:0]  sw_br  [3] = '{8'b1001_0101, 8'b1010_1001, 8'b1011_0010};

    initial begin
        logic [2:0] prev;
        rst_n = 1'b0; ex_valid = 1'b1; ex_opcode = 4'b0000; alu_result = 16'h0000;
        alu_ovfl = 1'b0; stall = 1'b0; flush = 1'b0; br_ccc = 3'b001;

        // reset held with a live ADD in EX
        step("rst0", 0, 1, 4'b0000, 16'h0000, 0, 0, 0, 3'b001, 3'b000, 1, 0);
        step("rst1", 0, 1, 4'b0000, 16'h0000, 0, 0, 0, 3'b001, 3'b000, 1, 0);
        idle("rst_rel", 3'b001, 3'b000, 0);

        // ADD overflow, then SUB to zero
        step("add_ov", 1, 1, 4'b0000, 16'h8000, 1, 0, 0, 3'b110, 3'b000, 1, 0);
        idle("add_ov_V", 3'b110, 3'b011, 1);
        idle("add_ov_N", 3'b011, 3'b011, 1);
        step("sub_z", 1, 1, 4'b0001, 16'h0000, 0, 0, 0, 3'b001, 3'b011, 1, 0);
        idle("sub_z_EQ", 3'b001, 3'b100, 1);
        idle("sub_z_GE", 3'b100, 3'b100, 1);

        // partial updates
        step("add_ov2", 1, 1, 4'b0000, 16'h8000, 1, 0, 0, 3'b000, 3'b100, 1, 0);
        step("xor_z", 1, 1, 4'b0010, 16'h0000, 0, 0, 0, 3'b000, 3'b011, 1, 1);
        step("red", 1, 1, 4'b0011, 16'h0000, 0, 0, 0, 3'b000, 3'b111, 0, 0);
        step("paddsb", 1, 1, 4'b0111, 16'h8001, 0, 0, 0, 3'b000, 3'b111, 0, 0);
        step("lw", 1, 1, 4'b1000, 16'h0005, 0, 0, 0, 3'b000, 3'b111, 0, 0);
        idle("hold", 3'b000, 3'b111, 0);

        // stall holds the write, release applies it
        step("add5", 1, 1, 4'b0000, 16'h0005, 0, 0, 0, 3'b001, 3'b111, 1, 1);
        for (int i = 0; i < 3; i++)
            step("stall", 1, 1, 4'b0000, 16'h0000, 0, 1, 0, 3'b001, 3'b000, 1, 0);
        step("stall_rel", 1, 1, 4'b0000, 16'h0000, 0, 0, 0, 3'b001, 3'b000, 1, 0);
        idle("after_rel", 3'b001, 3'b100, 1);

        // stall+flush: flush wins, nothing written
        step("add5b", 1, 1, 4'b0000, 16'h0005, 0, 0, 0, 3'b001, 3'b100, 1, 1);
        for (int i = 0; i < 3; i++)
            step("stall_flush", 1, 1, 4'b0000, 16'h0000, 0, 1, 1, 3'b001, 3'b000, 0, 0);
        step("flush", 1, 1, 4'b0000, 16'h0000, 1, 0, 1, 3'b001, 3'b000, 0, 0);
        idle("after_flush", 3'b001, 3'b000, 0);

        // bubble with a SUB opcode
        step("bubble", 1, 0, 4'b0001, 16'h0000, 0, 0, 0, 3'b001, 3'b000, 0, 0);
        idle("after_bubble", 3'b001, 3'b000, 0);

        // condition sweep over {Z,N} = 00, 01, 10
        prev = 3'b000;
        for (int s = 0; s < 3; s++) begin
            step("sweep_set", 1, 1, 4'b0000, sw_res[s], 0, 0, 0, 3'b111, prev, 1, 1);
            for (int c = 0; c < 8; c++)
                idle("sweep", 3'(c), sw_fl[s], sw_br[s][c]);
            prev = sw_fl[s];
        end

        // reset during a stall clears everything
        step("add_ov3", 1, 1, 4'b0000, 16'h8000, 1, 0, 0, 3'b111, 3'b100, 1, 1);
        step("rst_stall", 0, 1, 4'b0000, 16'h0000, 0, 1, 0, 3'b110, 3'b011, 1, 1);
        idle("after_rst", 3'b110, 3'b000, 0);

        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
